// File: rtl/rram_ctrl_pkg.sv
// Shared types and constants for the RRAM controller management-side loader.
package rram_ctrl_pkg;

  localparam int          INSTRUCTION_SIZE = 32;
  localparam int          ADDR_SIZE_IM     = 7;
  localparam logic [31:0] IM_BASE          = 32'h3000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RUN  = 2'd3
  } state_t;

  typedef struct packed {
    logic                        write;
    logic [ADDR_SIZE_IM-1:0]     addr;
    logic [INSTRUCTION_SIZE-1:0] data;
  } cmd_t;

  // Word address to controller byte address; the sum wraps at 32 bits.
  function automatic logic [31:0] im_byte_addr(input logic [31:0]             base,
                                               input logic [ADDR_SIZE_IM-1:0] word_addr);
    return base + 32'({word_addr, 2'b00});
  endfunction

endpackage

// File: rtl/rram_cmd_fifo.sv
// Command FIFO between the software-side push port and the bus replay FSM.
module rram_cmd_fifo
  import rram_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = {1'b1, {PTR_W{1'b0}}};

  cmd_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rram_wb_loader.sv
// Replays queued IM write/read-back commands as registered single-beat bus
// transactions on the RRAM controller slave port, then starts execution.
module rram_wb_loader #(
  parameter int          INSTRUCTION_SIZE = 32,
  parameter int          ADDR_SIZE_IM     = 7,
  parameter int          DEPTH            = 8,
  parameter int          READ_LATENCY     = 1,
  parameter logic [31:0] IM_BASE          = 32'h3000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_SIZE_IM-1:0]     cmd_addr,
  input  logic [INSTRUCTION_SIZE-1:0] cmd_data,
  output logic                        rsp_valid,
  output logic [INSTRUCTION_SIZE-1:0] rsp_data,
  input  logic                        go,
  input  logic                        stop,
  output logic                        busy,
  output logic [31:0]                 wishbone_address_bus,
  output logic [31:0]                 wishbone_data_in,
  output logic                        wbs_we_i,
  input  logic [31:0]                 wishbone_data_out,
  output logic                        enable_IM
);

  import rram_ctrl_pkg::state_t, rram_ctrl_pkg::cmd_t, rram_ctrl_pkg::im_byte_addr;
  import rram_ctrl_pkg::IDLE, rram_ctrl_pkg::WR, rram_ctrl_pkg::RD, rram_ctrl_pkg::RUN;

  localparam int               LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);

  state_t                      state_r, state_s;
  logic [31:0]                 addr_r, addr_s;
  logic [31:0]                 wdata_r, wdata_s;
  logic                        we_r, we_s;
  logic                        rsp_valid_r, rsp_valid_s;
  logic [INSTRUCTION_SIZE-1:0] rsp_data_r, rsp_data_s;
  logic                        enable_r, enable_s;
  logic                        go_pend_r, go_pend_s;
  logic [LAT_W-1:0]            lat_cnt_r, lat_cnt_s;
  logic                        ready_en_r;

  cmd_t                        cmd_in_s;
  cmd_t                        head_s;
  logic                        push_s;
  logic                        pop_s;
  logic [$clog2(DEPTH):0]      count_s;
  logic                        full_s;
  logic                        empty_s;

  // ready_en_r keeps cmd_ready low while reset is applied.
  assign cmd_ready = ready_en_r && !full_s && (state_r != RUN);
  assign push_s    = cmd_valid && cmd_ready;
  assign busy      = (count_s != '0) || (state_r == WR) || (state_r == RD);

  assign wishbone_address_bus = addr_r;
  assign wishbone_data_in     = wdata_r;
  assign wbs_we_i             = we_r;
  assign rsp_valid            = rsp_valid_r;
  assign rsp_data             = rsp_data_r;
  assign enable_IM            = enable_r;

  // Pack the incoming command for the FIFO.
  always_comb begin
    cmd_in_s       = '0;
    cmd_in_s.write = cmd_write;
    cmd_in_s.addr  = cmd_addr;
    cmd_in_s.data  = cmd_data;
  end

  rram_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (cmd_in_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Next-state, bus and response logic; stop always overrides go.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    we_s        = we_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    enable_s    = enable_r;
    lat_cnt_s   = lat_cnt_r;
    pop_s       = 1'b0;
    if (stop) begin
      go_pend_s = 1'b0;
    end else if (go) begin
      go_pend_s = 1'b1;
    end else begin
      go_pend_s = go_pend_r;
    end

    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          addr_s    = im_byte_addr(IM_BASE, head_s.addr);
          wdata_s   = head_s.write ? 32'(head_s.data) : 32'h0000_0000;
          we_s      = head_s.write;
          lat_cnt_s = LAT_LOAD;
          state_s   = head_s.write ? WR : RD;
        end else if (go_pend_r && !stop) begin
          state_s   = RUN;
          enable_s  = 1'b1;
          go_pend_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        state_s = IDLE;
        addr_s  = 32'h0000_0000;
        wdata_s = 32'h0000_0000;
        we_s    = 1'b0;
      end
      RD: begin
        if (lat_cnt_r == LAT_ONE) begin
          rsp_valid_s = 1'b1;
          rsp_data_s  = wishbone_data_out[INSTRUCTION_SIZE-1:0];
          state_s     = IDLE;
          addr_s      = 32'h0000_0000;
          wdata_s     = 32'h0000_0000;
          we_s        = 1'b0;
        end else begin
          lat_cnt_s = lat_cnt_r - LAT_ONE;
        end
      end
      RUN: begin
        if (stop) begin
          state_s  = IDLE;
          enable_s = 1'b0;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s  = IDLE;
        addr_s   = 32'h0000_0000;
        wdata_s  = 32'h0000_0000;
        we_s     = 1'b0;
        enable_s = 1'b0;
      end
    endcase
  end

  // State, bus and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      we_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      enable_r    <= 1'b0;
      go_pend_r   <= 1'b0;
      lat_cnt_r   <= '0;
      ready_en_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      we_r        <= we_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      enable_r    <= enable_s;
      go_pend_r   <= go_pend_s;
      lat_cnt_r   <= lat_cnt_s;
      ready_en_r  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rram_wb_loader.sv
// Scoreboard bench for rram_wb_loader with a combinational controller read model.
module tb_rram_wb_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } bus_t;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [6:0]  cmd_addr  = 7'h00;
  logic [31:0] cmd_data  = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        go        = 1'b0;
  logic        stop      = 1'b0;
  logic        busy;
  logic [31:0] wishbone_address_bus;
  logic [31:0] wishbone_data_in;
  logic        wbs_we_i;
  logic [31:0] wishbone_data_out;
  logic        enable_IM;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bus_t        exp_bus_q[$];
  logic [31:0] exp_rsp_q[$];
  int          txn_cyc_q[$];

  rram_wb_loader #(
    .INSTRUCTION_SIZE (32),
    .ADDR_SIZE_IM     (7),
    .DEPTH            (8),
    .READ_LATENCY     (1),
    .IM_BASE          (32'h3000_0000)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_write            (cmd_write),
    .cmd_addr             (cmd_addr),
    .cmd_data             (cmd_data),
    .rsp_valid            (rsp_valid),
    .rsp_data             (rsp_data),
    .go                   (go),
    .stop                 (stop),
    .busy                 (busy),
    .wishbone_address_bus (wishbone_address_bus),
    .wishbone_data_in     (wishbone_data_in),
    .wbs_we_i             (wbs_we_i),
    .wishbone_data_out    (wishbone_data_out),
    .enable_IM            (enable_IM)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_rdata(input logic [31:0] byte_addr);
    logic [31:0] w;
    w = (byte_addr - BASE) >> 2;
    if (w == 32'd5) return 32'h1234_5678;
    else return 32'hA5A5_0000 | w;
  endfunction

  assign wishbone_data_out = (wbs_we_i == 1'b0 && wishbone_address_bus != 32'h0)
                             ? model_rdata(wishbone_address_bus) : 32'h0;

  function automatic logic [31:0] exp_addr(input logic [6:0] a);
    return BASE + (32'(a) << 2);
  endfunction

  task automatic run_monitor();
    bus_t        e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (wishbone_address_bus !== 32'h0) begin
        txn_cyc_q.push_back(cyc);
        n_tests++;
        if (exp_bus_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_unexpected: got addr %h we %b, expected no transaction", wishbone_address_bus, wbs_we_i);
        end else begin
          e = exp_bus_q.pop_front();
          if (wishbone_address_bus !== e.addr || wbs_we_i !== e.we || (e.we && wishbone_data_in !== e.data)) begin
            n_fail++;
            $display("FAIL bus_txn: got addr %h data %h we %b, expected addr %h data %h we %b",
                     wishbone_address_bus, wishbone_data_in, wbs_we_i, e.addr, e.data, e.we);
          end
        end
      end else begin
        n_tests++;
        if (wishbone_data_in !== 32'h0 || wbs_we_i !== 1'b0) begin
          n_fail++;
          $display("FAIL bus_idle: got data %h we %b, expected 0 0", wishbone_data_in, wbs_we_i);
        end
      end
      if (rsp_valid === 1'b1) begin
        n_tests++;
        if (exp_rsp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got %h, expected no response", rsp_data);
        end else begin
          r = exp_rsp_q.pop_front();
          if (rsp_data !== r) begin
            n_fail++;
            $display("FAIL rsp_data: got %h, expected %h", rsp_data, r);
          end
        end
      end
    end
  endtask

  // Drives one command from a negedge and returns at the negedge after acceptance.
  task automatic drive_cmd(input logic w, input logic [6:0] a, input logic [31:0] d,
                           output bit ok, output int stalls);
    ok = 1'b0;
    stalls = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    for (int t = 0; t < 64; t++) begin
      if (cmd_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [70:0] outs;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {cmd_ready, rsp_valid, rsp_data, busy, wishbone_address_bus[0], wishbone_data_in[0], wbs_we_i, enable_IM, 32'(wishbone_address_bus | wishbone_data_in)};
    n_tests++;
    if (outs !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready %b busy %b, expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    bus_t e;
    bit   ok;
    int   st;
    e.addr = exp_addr(7'h05); e.data = 32'hDEAD_BEEF; e.we = 1'b1;
    exp_bus_q.push_back(e);
    drive_cmd(1'b1, 7'h05, 32'hDEAD_BEEF, ok, st);
    cmd_valid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_accept: got no accept, expected accept"); end
    @(negedge clk);
    n_tests++;
    if (wishbone_address_bus !== 32'h3000_0014 || wishbone_data_in !== 32'hDEAD_BEEF || wbs_we_i !== 1'b1) begin
      n_fail++;
      $display("FAIL write_bus: got %h %h %b, expected 30000014 deadbeef 1", wishbone_address_bus, wishbone_data_in, wbs_we_i);
    end
    @(negedge clk);
    n_tests++;
    if (wishbone_address_bus !== 32'h0 || wishbone_data_in !== 32'h0 || wbs_we_i !== 1'b0) begin
      n_fail++;
      $display("FAIL write_bus_idle: got %h %h %b, expected 0 0 0", wishbone_address_bus, wishbone_data_in, wbs_we_i);
    end
  endtask

  task automatic test_read();
    bus_t e;
    bit   ok;
    int   st;
    e.addr = exp_addr(7'h05); e.data = 32'h0; e.we = 1'b0;
    exp_bus_q.push_back(e);
    exp_rsp_q.push_back(32'h1234_5678);
    drive_cmd(1'b0, 7'h05, 32'hFFFF_FFFF, ok, st);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || wishbone_address_bus !== 32'h3000_0014 || wbs_we_i !== 1'b0) begin
      n_fail++;
      $display("FAIL read_issue: got rsp %b addr %h we %b, expected 0 30000014 0", rsp_valid, wishbone_address_bus, wbs_we_i);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL read_rsp: got valid %b data %h, expected 1 12345678", rsp_valid, rsp_data);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_rsp_pulse: got valid %b, expected 0", rsp_valid);
    end
  endtask

  task automatic test_fifo_full();
    bus_t        e;
    bit          ok;
    int          st, stalls_total, accepted, bad, waited;
    logic [6:0]  a;
    logic [31:0] d;
    stalls_total = 0; accepted = 0; bad = 0; waited = 0;
    txn_cyc_q.delete();
    for (int i = 0; i < 20; i++) begin
      a = 7'(i + 16);
      d = $urandom;
      e.addr = exp_addr(a); e.data = d; e.we = 1'b1;
      exp_bus_q.push_back(e);
      drive_cmd(1'b1, a, d, ok, st);
      if (ok) accepted++;
      stalls_total += st;
      if (st > 0) begin
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got busy %b, expected 1", busy); end
      end
    end
    cmd_valid = 1'b0;
    n_tests++;
    if (accepted != 20) begin n_fail++; $display("FAIL full_accepted: got %0d, expected 20", accepted); end
    n_tests++;
    if (stalls_total == 0) begin n_fail++; $display("FAIL full_ready_drop: got 0 stalls, expected at least 1"); end
    while ((exp_bus_q.size() != 0 || busy) && waited < 200) begin @(negedge clk); waited++; end
    n_tests++;
    if (waited >= 200) begin n_fail++; $display("FAIL full_drain: got timeout, expected drain"); end
    n_tests++;
    if (txn_cyc_q.size() != 20) begin n_fail++; $display("FAIL full_count: got %0d txns, expected 20", txn_cyc_q.size()); end
    for (int i = 1; i < txn_cyc_q.size(); i++) if (txn_cyc_q[i] - txn_cyc_q[i-1] != 2) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL full_spacing: got %0d gaps not 2, expected 0", bad); end
  endtask

  task automatic test_go_launch();
    bus_t e;
    bit   ok;
    int   st, e0, rise;
    rise = -1;
    for (int i = 0; i < 3; i++) begin
      e.addr = exp_addr(7'(i + 1)); e.data = 32'hC0DE_0000 + 32'(i); e.we = 1'b1;
      exp_bus_q.push_back(e);
    end
    go = 1'b1;
    drive_cmd(1'b1, 7'd1, 32'hC0DE_0000, ok, st);
    go = 1'b0;
    e0 = cyc;
    drive_cmd(1'b1, 7'd2, 32'hC0DE_0001, ok, st);
    drive_cmd(1'b1, 7'd3, 32'hC0DE_0002, ok, st);
    cmd_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (enable_IM === 1'b1) begin rise = cyc - e0; break; end
      @(negedge clk);
    end
    n_tests++;
    if (rise != 7) begin n_fail++; $display("FAIL go_rise_cycle: got %0d, expected 7", rise); end
    n_tests++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || exp_bus_q.size() != 0) begin
      n_fail++;
      $display("FAIL go_run_state: got ready %b busy %b pending %0d, expected 0 0 0", cmd_ready, busy, exp_bus_q.size());
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (enable_IM !== 1'b1) begin n_fail++; $display("FAIL go_hold: got %b, expected 1", enable_IM); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_tests++;
    if (enable_IM !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_fall: got en %b ready %b, expected 0 1", enable_IM, cmd_ready);
    end
  endtask

  task automatic test_go_stop();
    int seen;
    seen = 0;
    go = 1'b1; stop = 1'b1;
    @(negedge clk);
    go = 1'b0; stop = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (enable_IM !== 1'b0) seen++;
      @(negedge clk);
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL go_stop_same: got %0d enabled cycles, expected 0", seen); end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_tests++;
    if (enable_IM !== 1'b0) begin n_fail++; $display("FAIL go_empty_early: got %b, expected 0", enable_IM); end
    @(negedge clk);
    n_tests++;
    if (enable_IM !== 1'b1) begin n_fail++; $display("FAIL go_empty_rise: got %b, expected 1", enable_IM); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_tests++;
    if (enable_IM !== 1'b0) begin n_fail++; $display("FAIL go_empty_stop: got %b, expected 0", enable_IM); end
  endtask

  task automatic test_reset_mid_read();
    bus_t e;
    bit   ok;
    int   st;
    e.addr = exp_addr(7'h03); e.data = 32'h0; e.we = 1'b0;
    exp_bus_q.push_back(e);
    drive_cmd(1'b0, 7'h03, 32'h0, ok, st);
    drive_cmd(1'b0, 7'h04, 32'h0, ok, st);
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (wishbone_address_bus !== 32'h0 || wishbone_data_in !== 32'h0 || wbs_we_i !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd_bus: got %h %h %b rsp %b, expected all 0", wishbone_address_bus, wishbone_data_in, wbs_we_i, rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rd_release: got busy %b ready %b, expected 0 1", busy, cmd_ready);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_bus_q.size() != 0 || exp_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d bus %0d rsp pending, expected 0 0", exp_bus_q.size(), exp_rsp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_go_launch();
    test_go_stop();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
